// File: rtl/svm_detect_collector.sv
// Detection collector: thresholds per-window SVM scores, queues hits in a small
// FWFT FIFO toward the readout stage, and reports per-frame hit/best/overflow stats.
module svm_detect_collector #(
    parameter int SW_W       = 11,
    parameter int SCORE_W    = 24,
    parameter int COL_N      = 39,
    parameter int LAST_SW_ID = 1129,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [SW_W-1:0]    i_sw_id,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [SCORE_W-1:0] i_threshold,
    output logic               o_det_valid,
    input  logic               i_det_ready,
    output logic [4:0]         o_det_row,
    output logic [5:0]         o_det_col,
    output logic [SCORE_W-1:0] o_det_score,
    output logic               o_frame_done,
    output logic [CNT_W-1:0]   o_frame_hits,
    output logic [SW_W-1:0]    o_frame_best_id,
    output logic [SCORE_W-1:0] o_frame_best_score,
    output logic               o_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef struct packed {
        logic [4:0]         row;
        logic [5:0]         col;
        logic [SCORE_W-1:0] score;
    } det_t;

    det_t             mem [DEPTH];
    det_t             wr_ent, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             empty, full, hit, push, pop, drop, frame_end;

    logic [CNT_W-1:0]   hit_cnt, hit_cnt_nxt;
    logic [SW_W-1:0]    best_id, best_id_nxt;
    logic [SCORE_W-1:0] best_score, best_score_nxt;
    logic               first, ovf_acc, ovf_nxt;

    assign hit       = i_valid && ($signed(i_score) > $signed(i_threshold));
    assign frame_end = i_valid && (i_sw_id == SW_W'(LAST_SW_ID));
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && i_det_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = hit && (!full || pop);
    assign drop      = hit && full && !pop;

    assign wr_ent.row   = 5'(i_sw_id / SW_W'(COL_N));
    assign wr_ent.col   = 6'(i_sw_id % SW_W'(COL_N));
    assign wr_ent.score = i_score;

    assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign o_det_valid = !empty;
    assign o_det_row   = head.row;
    assign o_det_col   = head.col;
    assign o_det_score = head.score;

    // Storage is not reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_ent;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        hit_cnt_nxt    = hit_cnt;
        best_id_nxt    = best_id;
        best_score_nxt = best_score;
        ovf_nxt        = ovf_acc | drop;
        if (hit && hit_cnt != '1) hit_cnt_nxt = hit_cnt + 1'b1;
        // Strict compare: ties keep the earlier window.
        if (i_valid && (first || $signed(i_score) > $signed(best_score))) begin
            best_id_nxt    = i_sw_id;
            best_score_nxt = i_score;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt            <= '0;
            best_id            <= '0;
            best_score         <= '0;
            first              <= 1'b1;
            ovf_acc            <= 1'b0;
            o_frame_done       <= 1'b0;
            o_frame_hits       <= '0;
            o_frame_best_id    <= '0;
            o_frame_best_score <= '0;
            o_overflow         <= 1'b0;
        end else begin
            o_frame_done <= frame_end;
            if (frame_end) begin
                o_frame_hits       <= hit_cnt_nxt;
                o_frame_best_id    <= best_id_nxt;
                o_frame_best_score <= best_score_nxt;
                o_overflow         <= ovf_nxt;
                hit_cnt            <= '0;
                best_id            <= '0;
                best_score         <= '0;
                first              <= 1'b1;
                ovf_acc            <= 1'b0;
            end else if (i_valid) begin
                hit_cnt    <= hit_cnt_nxt;
                best_id    <= best_id_nxt;
                best_score <= best_score_nxt;
                first      <= 1'b0;
                ovf_acc    <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_svm_detect_collector.sv
// Directed bench for svm_detect_collector: FIFO ordering/backpressure/overflow,
// frame statistics, saturation and asynchronous reset.
module tb_svm_detect_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [10:0] i_sw_id = '0;
    logic [23:0] i_score = '0;
    logic [23:0] i_threshold = '0;
    logic        i_det_ready = 1'b0;
    logic        o_det_valid;
    logic [4:0]  o_det_row;
    logic [5:0]  o_det_col;
    logic [23:0] o_det_score;
    logic        o_frame_done;
    logic [9:0]  o_frame_hits;
    logic [10:0] o_frame_best_id;
    logic [23:0] o_frame_best_score;
    logic        o_overflow;

    int errors = 0;
    int checks = 0;

    svm_detect_collector dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sw_id(i_sw_id),
        .i_score(i_score), .i_threshold(i_threshold), .o_det_valid(o_det_valid),
        .i_det_ready(i_det_ready), .o_det_row(o_det_row), .o_det_col(o_det_col),
        .o_det_score(o_det_score), .o_frame_done(o_frame_done),
        .o_frame_hits(o_frame_hits), .o_frame_best_id(o_frame_best_id),
        .o_frame_best_score(o_frame_best_score), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] sc(input int v);
        return 24'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int score);
        i_valid = 1'b1;
        i_sw_id = 11'(id);
        i_score = 24'(score);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int hits, input int bid,
                             input int bsc, input int ovf);
        chk({tag, "_done"}, 32'(o_frame_done), 32'(1));
        chk({tag, "_hits"}, 32'(o_frame_hits), 32'(hits));
        chk({tag, "_best_id"}, 32'(o_frame_best_id), 32'(bid));
        chk({tag, "_best_score"}, 32'(o_frame_best_score), 32'(sc(bsc)));
        chk({tag, "_ovf"}, 32'(o_overflow), 32'(ovf));
    endtask

    initial begin
        int pulses;
        #12 rst = 1'b1;
        tick();
        chk("rst_valid", 32'(o_det_valid), 0);
        chk("rst_score", 32'(o_det_score), 0);
        chk("rst_hits", 32'(o_frame_hits), 0);
        chk("rst_best", 32'(o_frame_best_score), 0);
        chk("rst_done", 32'(o_frame_done), 0);

        // Strict threshold; 600 -> row 15 col 15
        send(600, 5);
        chk("t1_valid_rise", 32'(o_det_valid), 1);
        chk("t1_row", 32'(o_det_row), 15);
        chk("t1_col", 32'(o_det_col), 15);
        send(601, 0);
        send(602, -3);
        chk("t1_head_score", 32'(o_det_score), 32'(sc(5)));
        i_det_ready = 1'b1;
        tick();
        i_det_ready = 1'b0;
        chk("t1_single_entry", 32'(o_det_valid), 0);
        send(1129, -1);
        chk_frame("fA", 1, 600, 5, 0);
        tick();
        chk("fA_done_low", 32'(o_frame_done), 0);

        // Backpressure: 10 hits into 8 slots
        for (int i = 0; i < 10; i++) begin
            send(i, 100 + i);
            if (i == 7) chk("t2_full_head", 32'(o_det_score), 32'(sc(100)));
        end
        chk("t2_valid_held", 32'(o_det_valid), 1);
        chk("t2_head_stable", 32'(o_det_score), 32'(sc(100)));
        send(1129, -50);
        chk_frame("fB", 10, 9, 109, 1);

        // Full FIFO: push and pop in the same cycle
        i_det_ready = 1'b1;
        send(10, 200);
        i_det_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d", i), 32'(o_det_score),
                32'(sc(i < 7 ? 101 + i : 200)));
            i_det_ready = 1'b1;
            tick();
            i_det_ready = 1'b0;
        end
        chk("t3_empty", 32'(o_det_valid), 0);
        send(1129, -50);
        chk_frame("fC", 1, 10, 200, 0);

        // Full frame with two equal peaks
        i_det_ready = 1'b1;
        pulses = 0;
        for (int id = 0; id < 1130; id++) begin
            send(id, (id == 700 || id == 900) ? 50 : -100);
            if (o_frame_done) pulses++;
            if (id == 700) begin
                chk("t4_row", 32'(o_det_row), 17);
                chk("t4_col", 32'(o_det_col), 37);
            end
        end
        chk_frame("fD", 2, 700, 50, 0);
        chk("fD_pulses", 32'(pulses), 1);
        tick();
        chk("fD_done_low", 32'(o_frame_done), 0);
        chk("fD_drained", 32'(o_det_valid), 0);
        i_det_ready = 1'b0;

        // Negative threshold, no hits; out-of-range id is an ordinary window
        i_threshold = sc(-10);
        send(2000, -20);
        chk("t5_no_done", 32'(o_frame_done), 0);
        send(1128, -20);
        send(1129, -20);
        chk("t5_no_entry", 32'(o_det_valid), 0);
        chk_frame("fE", 0, 2000, -20, 0);

        // Hit counter saturation; push into empty FIFO with ready high
        i_threshold = sc(0);
        i_det_ready = 1'b1;
        send(0, 1);
        chk("t6_empty_push", 32'(o_det_valid), 1);
        chk("t6_empty_score", 32'(o_det_score), 32'(sc(1)));
        for (int id = 1; id < 1030; id++) send(id, 1);
        send(1129, 1);
        chk_frame("fF", 1023, 0, 1, 0);
        i_det_ready = 1'b0;
        tick();

        // Asynchronous reset with entries pending
        for (int i = 0; i < 5; i++) send(i, 10 + i);
        chk("t7_queued", 32'(o_det_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("t7_async_valid", 32'(o_det_valid), 0);
        chk("t7_async_hits", 32'(o_frame_hits), 0);
        #2 rst = 1'b1;
        tick();
        chk("t7_post_valid", 32'(o_det_valid), 0);
        chk("t7_post_best_id", 32'(o_frame_best_id), 0);
        chk("t7_post_best_sc", 32'(o_frame_best_score), 0);
        chk("t7_post_ovf", 32'(o_overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svm_detect_collector.md
Name: svm_detect_collector

Overview:
- Sits directly downstream of the SVM controller and PE accumulator.
- Per slide window it receives the final signed SVM score and window index, compares the score against a programmable threshold, and queues hits into a small FIFO.
- The FIFO has a valid/ready output handshake toward the result readout/drawing stage.
- It also produces per-frame summary statistics: hit count, best window and overflow flag.

Parameters:
SW_W, 11, slide window index width
SCORE_W, 24, signed SVM score width
COL_N, 39, slide windows per row
LAST_SW_ID, 1129, index of final window of a frame
DEPTH, 8, detection FIFO entries (power of two)
CNT_W, 10, per-frame hit counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous and active-low
i_valid  in  1  score/window pair valid (one-cycle pulse per scored window)
i_sw_id  in  SW_W  slide window index, 0..LAST_SW_ID
i_score  in  SCORE_W  signed SVM score (two's complement)
i_threshold  in  SCORE_W  signed detection threshold, quasi-static
o_det_valid  out  1  FIFO head valid
i_det_ready  in  1  consumer accepts head
o_det_row  out  5  window row = sw_id / COL_N
o_det_col  out  6  window column = sw_id % COL_N
o_det_score  out  SCORE_W  score of head entry
o_frame_done  out  1  one-cycle pulse at end of frame
o_frame_hits  out  CNT_W  hits in last completed frame
o_frame_best_id  out  SW_W  sw_id of max score in last frame
o_frame_best_score  out  SCORE_W  max score in last frame
o_overflow  out  1  at least one hit dropped in last completed frame

Behaviour:
- Reset (rst low, asynchronous): FIFO empty; o_det_valid=0; all frame outputs 0; o_frame_done=0; internal accumulators cleared. Data outputs read 0 when empty.
- Hit condition: i_valid && ($signed(i_score) > $signed(i_threshold)), strict compare. A score equal to the threshold is not a hit.
- Row/col: computed from i_sw_id by constant divide/modulo at write time and stored in the entry {row, col, score}.
- FIFO write: a hit sampled at edge k is written at edge k. If the FIFO was empty, o_det_valid=1 from just after edge k (first-word-fall-through).
- FIFO read: the head is popped at an edge where o_det_valid && i_det_ready. Head outputs hold stable while valid and not ready.
- Full FIFO with a hit:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the hit is dropped, the frame overflow flag is set, and the hit still counts in hits and best-score tracking.
- Empty FIFO with simultaneous push and pop: i_det_ready is ignored because o_det_valid=0; the push lands normally.
- Pointers: log2(DEPTH)+1 bits, wrap-around. Full when the MSBs differ and the LSBs are equal.
- Per-frame accumulators:
  - hit_cnt increments per hit and saturates at 2^CNT_W-1.
  - best tracking takes i_score when i_valid and (first valid window of the frame, or i_score > best). Ties keep the earlier window. Best tracks all valid windows, not only hits.
- Frame end: i_valid && i_sw_id==LAST_SW_ID. At that edge:
  - o_frame_hits, o_frame_best_*, o_overflow latch the values including the current window.
  - o_frame_done pulses high for exactly one cycle after that edge.
  - Accumulators restart so the next i_valid is the first of the new frame.
- o_frame_* outputs hold until the next frame end.
- FIFO contents are not flushed at frame end.
- i_sw_id > LAST_SW_ID: treated as a normal window, with no frame end.
- Reset mid-operation: everything clears immediately, including pending FIFO entries.

Test Plan:
- Threshold=0; windows 600 (score +5), 601 (score 0), 602 (score -3) -> one entry row=15 col=15 score=5; o_det_valid rises the cycle after the 600 sample.
- i_det_ready held 0; 10 consecutive hits -> 8 entries held, o_det_valid stable, head unchanged. At frame end: o_overflow=1, o_frame_hits=10.
- FIFO full, hit and pop in the same cycle -> push accepted, occupancy stays 8, no overflow.
- Frame of 1130 windows with scores -100 everywhere except ids 700 and 900, both =50 -> o_frame_done single pulse after id 1129; best_id=700, best_score=50, hits=2 (threshold 0).
- Threshold=-10, all scores -20 -> no entries, hits=0; best_score=-20, best_id=first window of the frame.
- Assert rst low mid-burst with 5 entries queued -> o_det_valid drops asynchronously. After release, FIFO empty and o_frame_* all 0.
